// File: rtl/vga_pic_sprite.sv
// Picture generator: selectable background pattern plus a ROM-backed sprite that can
// bounce one step per frame, with optional colour-key transparency. One pixel of latency.
module vga_pic_sprite #(
    parameter int          H_VALID   = 640,
    parameter int          V_VALID   = 480,
    parameter int          IMG_W     = 100,
    parameter int          IMG_H     = 100,
    parameter int          ADDR_W    = 14,
    parameter int          STEP      = 1,
    parameter logic [15:0] KEY_COLOR = 16'hF81F
) (
    input  logic              vga_clk,
    input  logic              sys_rst_n,
    input  logic [9:0]        pix_x,
    input  logic [9:0]        pix_y,
    input  logic [1:0]        mode,
    input  logic [15:0]       bg_color,
    input  logic              move_en,
    input  logic              key_en,
    output logic              rom_rd_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic [15:0]       pix_data,
    output logic              frame_end
);

    localparam logic [9:0]        H_LIM     = 10'(H_VALID);
    localparam logic [9:0]        V_LIM     = 10'(V_VALID);
    localparam logic [10:0]       X_MAX     = 11'(H_VALID - IMG_W);
    localparam logic [10:0]       Y_MAX     = 11'(V_VALID - IMG_H);
    localparam logic [10:0]       X_CTR     = 11'((H_VALID - IMG_W) / 2);
    localparam logic [10:0]       Y_CTR     = 11'((V_VALID - IMG_H) / 2);
    localparam logic [10:0]       STEP_W    = 11'(STEP);
    localparam logic [10:0]       IMG_W_W   = 11'(IMG_W);
    localparam logic [10:0]       IMG_H_W   = 11'(IMG_H);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(IMG_W * IMG_H - 1);
    localparam int                BAR_W     = H_VALID / 10;

    typedef enum logic [1:0] {
        MODE_BARS    = 2'd0,
        MODE_CHECKER = 2'd1,
        MODE_SOLID   = 2'd2,
        MODE_GRID    = 2'd3
    } mode_e;

    mode_e             mode_q;
    logic [10:0]       img_x_q, img_x_d;
    logic [10:0]       img_y_q, img_y_d;
    logic              dir_x_q, dir_x_d;
    logic              dir_y_q, dir_y_d;
    logic [ADDR_W-1:0] rom_addr_q;
    logic              img_valid_q;
    logic [15:0]       bg_q, bg_d;
    logic              frame_end_q;
    logic              fe_hit;
    logic              in_window;
    logic              active;
    logic [3:0]        bar_idx;
    logic              keyed;

    function automatic logic [15:0] bar_color(input logic [3:0] idx);
        case (idx)
            4'd0:    bar_color = 16'hF800;
            4'd1:    bar_color = 16'hFC00;
            4'd2:    bar_color = 16'hFFE0;
            4'd3:    bar_color = 16'h07E0;
            4'd4:    bar_color = 16'h07FF;
            4'd5:    bar_color = 16'h001F;
            4'd6:    bar_color = 16'hF81F;
            4'd7:    bar_color = 16'h0000;
            4'd8:    bar_color = 16'hFFFF;
            4'd9:    bar_color = 16'hD69A;
            default: bar_color = 16'h0000;
        endcase
    endfunction

    assign fe_hit    = (pix_x == H_LIM - 10'd1) && (pix_y == V_LIM - 10'd1);
    assign in_window = ({1'b0, pix_x} >= img_x_q) && ({1'b0, pix_x} < img_x_q + IMG_W_W) &&
                       ({1'b0, pix_y} >= img_y_q) && ({1'b0, pix_y} < img_y_q + IMG_H_W);
    assign rom_rd_en = in_window && sys_rst_n;
    assign rom_addr  = rom_addr_q;
    assign frame_end = frame_end_q;

    // Bounce rules: clamp to the edge and reverse direction on reaching it.
    always_comb begin
        img_x_d = img_x_q;
        img_y_d = img_y_q;
        dir_x_d = dir_x_q;
        dir_y_d = dir_y_q;
        if (dir_x_q) begin
            if (img_x_q + STEP_W >= X_MAX) begin
                img_x_d = X_MAX;
                dir_x_d = 1'b0;
            end else begin
                img_x_d = img_x_q + STEP_W;
            end
        end else begin
            if (img_x_q <= STEP_W) begin
                img_x_d = '0;
                dir_x_d = 1'b1;
            end else begin
                img_x_d = img_x_q - STEP_W;
            end
        end
        if (dir_y_q) begin
            if (img_y_q + STEP_W >= Y_MAX) begin
                img_y_d = Y_MAX;
                dir_y_d = 1'b0;
            end else begin
                img_y_d = img_y_q + STEP_W;
            end
        end else begin
            if (img_y_q <= STEP_W) begin
                img_y_d = '0;
                dir_y_d = 1'b1;
            end else begin
                img_y_d = img_y_q - STEP_W;
            end
        end
    end

    always_comb begin
        active  = (pix_x < H_LIM) && (pix_y < V_LIM);
        bar_idx = 4'd0;
        for (int i = 1; i < 10; i++) begin
            if ({1'b0, pix_x} >= 11'(i * BAR_W)) begin
                bar_idx = 4'(i);
            end
        end
        bg_d = 16'h0000;
        if (active) begin
            case (mode_q)
                MODE_BARS:    bg_d = bar_color(bar_idx);
                MODE_CHECKER: bg_d = (pix_x[5] ^ pix_y[5]) ? 16'hFFFF : 16'h0000;
                MODE_SOLID:   bg_d = bg_color;
                MODE_GRID:    bg_d = (pix_x[4:0] == 5'd0 || pix_y[4:0] == 5'd0) ? 16'hFFFF : 16'h0000;
                default:      bg_d = 16'h0000;
            endcase
        end
    end

    // Mode and position only change at the frame boundary, so a frame never tears.
    always_ff @(posedge vga_clk) begin
        if (!sys_rst_n) begin
            mode_q      <= MODE_BARS;
            img_x_q     <= X_CTR;
            img_y_q     <= Y_CTR;
            dir_x_q     <= 1'b1;
            dir_y_q     <= 1'b1;
            rom_addr_q  <= '0;
            img_valid_q <= 1'b0;
            bg_q        <= 16'h0000;
            frame_end_q <= 1'b0;
        end else begin
            frame_end_q <= fe_hit;
            img_valid_q <= rom_rd_en;
            bg_q        <= bg_d;
            if (fe_hit) begin
                mode_q     <= mode_e'(mode);
                rom_addr_q <= '0;
                if (move_en) begin
                    img_x_q <= img_x_d;
                    img_y_q <= img_y_d;
                    dir_x_q <= dir_x_d;
                    dir_y_q <= dir_y_d;
                end
            end else if (rom_rd_en) begin
                rom_addr_q <= (rom_addr_q == ADDR_LAST) ? '0 : rom_addr_q + 1'b1;
            end
        end
    end

    assign keyed    = key_en && (rom_data == KEY_COLOR);
    assign pix_data = (img_valid_q && !keyed) ? rom_data : bg_q;

endmodule

// File: tb/tb_vga_pic_sprite.sv
// Directed bench for vga_pic_sprite: reset, bars, ROM alignment, bounce, colour key,
// frame-boundary mode change and mid-frame reset.
module tb_vga_pic_sprite;

    localparam int STEP = 10;

    logic        vga_clk   = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [9:0]  pix_x     = 10'd700;
    logic [9:0]  pix_y     = 10'd500;
    logic [1:0]  mode      = 2'd0;
    logic [15:0] bg_color  = 16'h0000;
    logic        move_en   = 1'b0;
    logic        key_en    = 1'b0;
    logic        rom_rd_en;
    logic [13:0] rom_addr;
    logic [15:0] rom_data  = 16'h0000;
    logic [15:0] pix_data;
    logic        frame_end;
    logic        romKey    = 1'b0;

    int total = 0;
    int bad   = 0;

    vga_pic_sprite #(.STEP(STEP)) dut (
        .vga_clk   (vga_clk),
        .sys_rst_n (sys_rst_n),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .mode      (mode),
        .bg_color  (bg_color),
        .move_en   (move_en),
        .key_en    (key_en),
        .rom_rd_en (rom_rd_en),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .pix_data  (pix_data),
        .frame_end (frame_end)
    );

    always #5 vga_clk = ~vga_clk;

    // One-cycle-latency ROM: returns its own address, or the key colour when romKey is set.
    always @(posedge vga_clk) begin
        if (rom_rd_en) begin
            rom_data <= romKey ? 16'hF81F : {2'b00, rom_addr};
        end
    end

    // Present one pixel coordinate; outputs are read 1 time unit after the falling edge.
    task automatic setPix(input int x, input int y);
        @(negedge vga_clk);
        pix_x = 10'(x);
        pix_y = 10'(y);
        #1;
    endtask

    task automatic doReset;
        @(negedge vga_clk);
        pix_x = 10'd700;
        pix_y = 10'd500;
        sys_rst_n = 1'b0;
        repeat (5) @(negedge vga_clk);
        sys_rst_n = 1'b1;
    endtask

    task automatic endFrame;
        setPix(639, 479);
        setPix(700, 500);
    endtask

    task automatic test_reset;
        @(negedge vga_clk);
        pix_x = 10'd300;
        pix_y = 10'd200;
        sys_rst_n = 1'b0;
        repeat (5) @(negedge vga_clk);
        #1;
        total++; if (pix_data !== 16'h0000) begin bad++; $display("[TB] FAIL rst_pix: got %h want %h", pix_data, 16'h0000); end
        total++; if (frame_end !== 1'b0) begin bad++; $display("[TB] FAIL rst_fe: got %b want 0", frame_end); end
        total++; if (rom_rd_en !== 1'b0) begin bad++; $display("[TB] FAIL rst_rd: got %b want 0", rom_rd_en); end
        total++; if (rom_addr !== 14'd0) begin bad++; $display("[TB] FAIL rst_addr: got %0d want 0", rom_addr); end
        pix_x = 10'd700;
        pix_y = 10'd500;
        sys_rst_n = 1'b1;

        setPix(0, 0);
        setPix(1, 0);
        total++; if (pix_data !== 16'hF800) begin bad++; $display("[TB] FAIL bar_x0: got %h want %h", pix_data, 16'hF800); end
        setPix(191, 0);
        setPix(192, 0);
        total++; if (pix_data !== 16'hFFE0) begin bad++; $display("[TB] FAIL bar_x191: got %h want %h", pix_data, 16'hFFE0); end
        setPix(193, 0);
        total++; if (pix_data !== 16'h07E0) begin bad++; $display("[TB] FAIL bar_x192: got %h want %h", pix_data, 16'h07E0); end
        setPix(639, 0);
        setPix(640, 0);
        total++; if (pix_data !== 16'hD69A) begin bad++; $display("[TB] FAIL bar_x639: got %h want %h", pix_data, 16'hD69A); end
        setPix(641, 0);
        total++; if (pix_data !== 16'h0000) begin bad++; $display("[TB] FAIL blank_x640: got %h want %h", pix_data, 16'h0000); end

        setPix(270, 189);
        total++; if (rom_rd_en !== 1'b0) begin bad++; $display("[TB] FAIL rd_270_189: got %b want 0", rom_rd_en); end
        setPix(269, 190);
        total++; if (rom_rd_en !== 1'b0) begin bad++; $display("[TB] FAIL rd_269_190: got %b want 0", rom_rd_en); end
        for (int y = 190; y < 290; y++) begin
            for (int x = 270; x < 370; x++) begin
                setPix(x, y);
                if (x == 270 && y == 190) begin
                    total++; if (rom_rd_en !== 1'b1) begin bad++; $display("[TB] FAIL rd_first: got %b want 1", rom_rd_en); end
                    total++; if (rom_addr !== 14'd0) begin bad++; $display("[TB] FAIL addr_first: got %0d want 0", rom_addr); end
                end
                if (x == 369 && y == 289) begin
                    total++; if (rom_addr !== 14'd9999) begin bad++; $display("[TB] FAIL addr_last: got %0d want 9999", rom_addr); end
                end
            end
        end
        setPix(700, 300);

        setPix(639, 479);
        total++; if (frame_end !== 1'b0) begin bad++; $display("[TB] FAIL fe_early: got %b want 0", frame_end); end
        setPix(700, 500);
        total++; if (frame_end !== 1'b1) begin bad++; $display("[TB] FAIL fe_pulse: got %b want 1", frame_end); end
        setPix(700, 501);
        total++; if (frame_end !== 1'b0) begin bad++; $display("[TB] FAIL fe_clear: got %b want 0", frame_end); end
    endtask

    task automatic test_alignment;
        int prevX = 269;
        int prevY = 190;
        setPix(269, 190);
        for (int y = 190; y < 290; y++) begin
            for (int x = 270; x < 370; x++) begin
                setPix(x, y);
                if (prevX == 269 && prevY == 190) begin
                    total++; if (pix_data !== 16'h07FF) begin bad++; $display("[TB] FAIL align_left_bg: got %h want %h", pix_data, 16'h07FF); end
                end
                if (prevX == 270 && prevY == 190) begin
                    total++; if (pix_data !== 16'd0) begin bad++; $display("[TB] FAIL align_first: got %0d want 0", pix_data); end
                end
                if (prevX == 369 && prevY == 190) begin
                    total++; if (pix_data !== 16'd99) begin bad++; $display("[TB] FAIL align_row_end: got %0d want 99", pix_data); end
                end
                if (prevX == 300 && prevY == 200) begin
                    total++; if (pix_data !== 16'd1030) begin bad++; $display("[TB] FAIL align_mid: got %0d want 1030", pix_data); end
                end
                prevX = x;
                prevY = y;
            end
        end
        setPix(270, 190);
        total++; if (pix_data !== 16'd9999) begin bad++; $display("[TB] FAIL align_last: got %0d want 9999", pix_data); end
        total++; if (rom_addr !== 14'd0) begin bad++; $display("[TB] FAIL addr_wrap: got %0d want 0", rom_addr); end
        setPix(700, 500);
        endFrame;
    endtask

    task automatic test_color_key;
        mode = 2'd2;
        bg_color = 16'h1234;
        key_en = 1'b1;
        romKey = 1'b1;
        endFrame;
        setPix(10, 10);
        setPix(300, 200);
        total++; if (pix_data !== 16'h1234) begin bad++; $display("[TB] FAIL solid_bg: got %h want %h", pix_data, 16'h1234); end
        setPix(301, 200);
        total++; if (pix_data !== 16'h1234) begin bad++; $display("[TB] FAIL key_on: got %h want %h", pix_data, 16'h1234); end
        key_en = 1'b0;
        setPix(302, 200);
        total++; if (pix_data !== 16'hF81F) begin bad++; $display("[TB] FAIL key_off: got %h want %h", pix_data, 16'hF81F); end
        bg_color = 16'hABCD;
        setPix(20, 10);
        setPix(21, 10);
        total++; if (pix_data !== 16'hABCD) begin bad++; $display("[TB] FAIL solid_live: got %h want %h", pix_data, 16'hABCD); end
        romKey = 1'b0;
        endFrame;
    endtask

    task automatic test_mode_change;
        mode = 2'd0;
        endFrame;
        setPix(0, 100);
        setPix(1, 100);
        total++; if (pix_data !== 16'hF800) begin bad++; $display("[TB] FAIL mode_bars: got %h want %h", pix_data, 16'hF800); end
        mode = 2'd1;
        setPix(32, 200);
        setPix(32, 300);
        total++; if (pix_data !== 16'hF800) begin bad++; $display("[TB] FAIL mid_y200: got %h want %h", pix_data, 16'hF800); end
        setPix(33, 300);
        total++; if (pix_data !== 16'hF800) begin bad++; $display("[TB] FAIL mid_y300: got %h want %h", pix_data, 16'hF800); end
        endFrame;
        setPix(32, 0);
        setPix(0, 0);
        total++; if (pix_data !== 16'hFFFF) begin bad++; $display("[TB] FAIL chk_32_0: got %h want %h", pix_data, 16'hFFFF); end
        setPix(1, 0);
        total++; if (pix_data !== 16'h0000) begin bad++; $display("[TB] FAIL chk_0_0: got %h want %h", pix_data, 16'h0000); end
        mode = 2'd3;
        endFrame;
        setPix(32, 5);
        setPix(33, 5);
        total++; if (pix_data !== 16'hFFFF) begin bad++; $display("[TB] FAIL grid_line: got %h want %h", pix_data, 16'hFFFF); end
        setPix(34, 5);
        total++; if (pix_data !== 16'h0000) begin bad++; $display("[TB] FAIL grid_gap: got %h want %h", pix_data, 16'h0000); end
        mode = 2'd0;
        endFrame;
    endtask

    task automatic test_bounce;
        int fr [4] = '{19, 20, 27, 28};
        int ex [4] = '{460, 470, 540, 530};
        int ey [4] = '{380, 370, 300, 290};
        int k = 0;
        doReset;
        move_en = 1'b1;
        for (int f = 1; f <= 28; f++) begin
            endFrame;
            if (k < 4 && f == fr[k]) begin
                setPix(ex[k], ey[k]);
                total++; if (rom_rd_en !== 1'b1) begin bad++; $display("[TB] FAIL bounce_in f%0d: got %b want 1", f, rom_rd_en); end
                setPix(ex[k] - 1, ey[k]);
                total++; if (rom_rd_en !== 1'b0) begin bad++; $display("[TB] FAIL bounce_left f%0d: got %b want 0", f, rom_rd_en); end
                setPix(ex[k], ey[k] - 1);
                total++; if (rom_rd_en !== 1'b0) begin bad++; $display("[TB] FAIL bounce_above f%0d: got %b want 0", f, rom_rd_en); end
                k++;
            end
        end
        move_en = 1'b0;
    endtask

    task automatic test_reset_mid;
        doReset;
        move_en = 1'b1;
        repeat (5) endFrame;
        move_en = 1'b0;
        setPix(320, 240);
        total++; if (rom_rd_en !== 1'b1) begin bad++; $display("[TB] FAIL moved_in: got %b want 1", rom_rd_en); end
        setPix(319, 240);
        total++; if (rom_rd_en !== 1'b0) begin bad++; $display("[TB] FAIL moved_left: got %b want 0", rom_rd_en); end
        setPix(100, 250);
        mode = 2'd1;
        setPix(330, 250);
        sys_rst_n = 1'b0;
        #1;
        total++; if (rom_rd_en !== 1'b0) begin bad++; $display("[TB] FAIL midrst_rd: got %b want 0", rom_rd_en); end
        setPix(639, 479);
        total++; if (pix_data !== 16'h0000) begin bad++; $display("[TB] FAIL midrst_pix: got %h want %h", pix_data, 16'h0000); end
        setPix(700, 500);
        total++; if (frame_end !== 1'b0) begin bad++; $display("[TB] FAIL midrst_fe: got %b want 0", frame_end); end
        total++; if (rom_addr !== 14'd0) begin bad++; $display("[TB] FAIL midrst_addr: got %0d want 0", rom_addr); end
        total++; if (pix_data !== 16'h0000) begin bad++; $display("[TB] FAIL midrst_pix2: got %h want %h", pix_data, 16'h0000); end
        sys_rst_n = 1'b1;
        setPix(270, 190);
        total++; if (rom_rd_en !== 1'b1) begin bad++; $display("[TB] FAIL recentre_in: got %b want 1", rom_rd_en); end
        setPix(269, 190);
        total++; if (rom_rd_en !== 1'b0) begin bad++; $display("[TB] FAIL recentre_left: got %b want 0", rom_rd_en); end
        setPix(270, 189);
        total++; if (rom_rd_en !== 1'b0) begin bad++; $display("[TB] FAIL recentre_above: got %b want 0", rom_rd_en); end
        setPix(0, 10);
        setPix(1, 10);
        total++; if (pix_data !== 16'hF800) begin bad++; $display("[TB] FAIL recentre_mode: got %h want %h", pix_data, 16'hF800); end
        mode = 2'd0;
    endtask

    initial begin
        $display("[TB] start");
        test_reset;
        test_alignment;
        test_color_key;
        test_mode_change;
        test_bounce;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
